siphash_core: RTL and testbench

Parametrised SipHash-c-d keyed hash engine with a streaming 64-bit message interface and optional 128-bit output. It executes one SipRound per clock, absorbs any message length, and applies the standard length/padding rule internally. It replaces the fixed-function hash stub as the hashing datapath behind the `cs`/`we` register front end.

---
 rtl/siphash_pkg.sv | 38 +++
 rtl/siphash_round.sv | 39 +++
 rtl/siphash_core.sv | 181 ++++++++++++++++++
 tb/tb_siphash_core.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_pkg.sv
// Shared constants, state encoding and the 4x64 state word for the SipHash engine.
// Pure definitions only; no clocked logic.
package siphash_pkg;

   localparam logic [63:0] IV0 = 64'h736f6d6570736575;
   localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
   localparam logic [63:0] IV2 = 64'h6c7967656e657261;
   localparam logic [63:0] IV3 = 64'h7465646279746573;

   localparam logic [63:0] FIN_C64  = 64'h00000000000000ff;
   localparam logic [63:0] FIN_C128 = 64'h00000000000000ee;
   localparam logic [63:0] FIN2_C   = 64'h00000000000000dd;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_MSG,
      ST_COMP,
      ST_FIN1,
      ST_FIN2,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [63:0] v3;
      logic [63:0] v2;
      logic [63:0] v1;
      logic [63:0] v0;
   } sip_state_t;

   function automatic int rcnt_width(input int c, input int d);
      return $clog2(((c > d) ? c : d) + 1);
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

endpackage

// File: rtl/siphash_round.sv
// One combinational SipRound over the four 64-bit state words; zero latency.
// No flow control: output follows input within the same cycle.
module siphash_round
   import siphash_pkg::*;
(
   input  sip_state_t s_in,
   output sip_state_t s_out
);

   logic [63:0] v0, v1, v2, v3;

   always_comb begin
      v0 = s_in.v0;
      v1 = s_in.v1;
      v2 = s_in.v2;
      v3 = s_in.v3;

      v0 = v0 + v1;
      v1 = rotl(v1, 13);
      v1 = v1 ^ v0;
      v0 = rotl(v0, 32);

      v2 = v2 + v3;
      v3 = rotl(v3, 16);
      v3 = v3 ^ v2;

      v0 = v0 + v3;
      v3 = rotl(v3, 21);
      v3 = v3 ^ v0;

      v2 = v2 + v1;
      v1 = rotl(v1, 17);
      v1 = v1 ^ v2;
      v2 = rotl(v2, 32);

      s_out = '{v3: v3, v2: v2, v1: v1, v0: v0};
   end

endmodule

// File: rtl/siphash_core.sv
// SipHash-c-d engine, one SipRound per clock; done follows the last beat by C+D*(1+HASH128)+1 cycles.
// msg_ready is high only while waiting for a beat, so each word costs C_ROUNDS+1 cycles.
module siphash_core
   import siphash_pkg::*;
#(
   parameter int C_ROUNDS = 2,
   parameter int D_ROUNDS = 4,
   parameter int HASH128  = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cs,
   input  logic                        we,
   input  logic [127:0]                key,
   input  logic                        msg_valid,
   output logic                        msg_ready,
   input  logic [63:0]                 msg_data,
   input  logic                        msg_last,
   input  logic [2:0]                  msg_bytes,
   output logic                        done,
   output logic [64*(1+HASH128)-1:0]   result,
   output logic                        busy
);

   localparam int          CW       = rcnt_width(C_ROUNDS, D_ROUNDS);
   localparam logic [63:0] FIN1_C   = (HASH128 != 0) ? FIN_C128 : FIN_C64;
   localparam logic [63:0] V1_TWEAK = (HASH128 != 0) ? FIN_C128 : 64'h0;

   state_t      state;
   sip_state_t  v;
   sip_state_t  r_in;
   sip_state_t  r_out;
   logic [63:0] m;
   logic [63:0] m_blk;
   logic [63:0] r_xor;
   logic [63:0] half0;
   logic [63:0] res_lo;
   logic [7:0]  byte_cnt;
   logic [7:0]  cnt_next;
   logic [CW-1:0] rcnt;
   logic        last_q;
   logic        c_last;
   logic        d_last;

   assign c_last   = (rcnt == CW'(C_ROUNDS - 1));
   assign d_last   = (rcnt == CW'(D_ROUNDS - 1));
   assign cnt_next = msg_last ? (byte_cnt + {5'b0, msg_bytes}) : (byte_cnt + 8'd8);

   // Final beat: drop bytes past msg_bytes and put the running length in the top byte.
   always_comb begin
      m_blk = msg_data;
      if (msg_last) begin
         for (int i = 0; i < 8; i++) begin
            if (i >= int'(msg_bytes)) m_blk[8*i +: 8] = 8'h00;
         end
         m_blk[63:56] = cnt_next;
      end
   end

   // Finalization tweaks only apply to the first round of each phase.
   always_comb begin
      r_in = v;
      if (state == ST_FIN1 && rcnt == '0) r_in.v2 = v.v2 ^ FIN1_C;
      if (state == ST_FIN2 && rcnt == '0) r_in.v1 = v.v1 ^ FIN2_C;
   end

   siphash_round u_round (
      .s_in  (r_in),
      .s_out (r_out)
   );

   assign r_xor = r_out.v0 ^ r_out.v1 ^ r_out.v2 ^ r_out.v3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         v         <= '0;
         m         <= '0;
         last_q    <= 1'b0;
         byte_cnt  <= '0;
         rcnt      <= '0;
         half0     <= '0;
         res_lo    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         msg_ready <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs && we) begin
                  v <= '{v3: key[127:64] ^ IV3,
                         v2: key[63:0]   ^ IV2,
                         v1: key[127:64] ^ IV1 ^ V1_TWEAK,
                         v0: key[63:0]   ^ IV0};
                  byte_cnt  <= '0;
                  rcnt      <= '0;
                  busy      <= 1'b1;
                  msg_ready <= 1'b1;
                  state     <= ST_WAIT_MSG;
               end
            end
            ST_WAIT_MSG: begin
               if (msg_valid) begin
                  m         <= m_blk;
                  v.v3      <= v.v3 ^ m_blk;
                  byte_cnt  <= cnt_next;
                  last_q    <= msg_last;
                  rcnt      <= '0;
                  msg_ready <= 1'b0;
                  state     <= ST_COMP;
               end
            end
            ST_COMP: begin
               v    <= r_out;
               rcnt <= rcnt + 1'b1;
               if (c_last) begin
                  v.v0 <= r_out.v0 ^ m;
                  rcnt <= '0;
                  if (last_q) begin
                     state <= ST_FIN1;
                  end else begin
                     state     <= ST_WAIT_MSG;
                     msg_ready <= 1'b1;
                  end
               end
            end
            ST_FIN1: begin
               v    <= r_out;
               rcnt <= rcnt + 1'b1;
               if (d_last) begin
                  rcnt  <= '0;
                  half0 <= r_xor;
                  if (HASH128 != 0) begin
                     state <= ST_FIN2;
                  end else begin
                     res_lo <= r_xor;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_FIN2: begin
               v    <= r_out;
               rcnt <= rcnt + 1'b1;
               if (d_last) begin
                  rcnt   <= '0;
                  res_lo <= half0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   generate
      if (HASH128 != 0) begin : g_h128
         logic [63:0] res_hi;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               res_hi <= '0;
            end else if (state == ST_FIN2 && d_last) begin
               res_hi <= r_xor;
            end
         end
         assign result = {res_hi, res_lo};
      end else begin : g_h64
         assign result = res_lo;
      end
   endgenerate

endmodule

// File: tb/tb_siphash_core.sv
// Bench for siphash_core: three configurations (2-4, 2-4/128, 4-8) sharing one stimulus port.
module tb_siphash_core;

   localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;

   logic         clk;
   logic         rst_n;
   logic [2:0]   cs_v;
   logic         we;
   logic [127:0] key;
   logic         msg_valid;
   logic [63:0]  msg_data;
   logic         msg_last;
   logic [2:0]   msg_bytes;
   logic [2:0]   rdy, dn, bsy;
   logic [63:0]  res_a, res_c;
   logic [127:0] res_b;

   int           sel;
   logic         rdy_s, dn_s, bsy_s;
   logic [127:0] res_s;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int t_last = 0;
   logic prev_done = 1'b0;

   logic [7:0] msg [0:511];

   typedef struct { logic [127:0] res; int lat; } sb_t;
   sb_t sb[$];

   typedef struct {
      int sel; int len; logic [127:0] k; logic [127:0] exp; bit known; bit tchk;
   } vec_t;
   vec_t vt[8];

   siphash_core #(.C_ROUNDS(2), .D_ROUNDS(4), .HASH128(0)) u_a (
      .clk(clk), .rst_n(rst_n), .cs(cs_v[0]), .we(we), .key(key),
      .msg_valid(msg_valid), .msg_ready(rdy[0]), .msg_data(msg_data),
      .msg_last(msg_last), .msg_bytes(msg_bytes),
      .done(dn[0]), .result(res_a), .busy(bsy[0]));

   siphash_core #(.C_ROUNDS(2), .D_ROUNDS(4), .HASH128(1)) u_b (
      .clk(clk), .rst_n(rst_n), .cs(cs_v[1]), .we(we), .key(key),
      .msg_valid(msg_valid), .msg_ready(rdy[1]), .msg_data(msg_data),
      .msg_last(msg_last), .msg_bytes(msg_bytes),
      .done(dn[1]), .result(res_b), .busy(bsy[1]));

   siphash_core #(.C_ROUNDS(4), .D_ROUNDS(8), .HASH128(0)) u_c (
      .clk(clk), .rst_n(rst_n), .cs(cs_v[2]), .we(we), .key(key),
      .msg_valid(msg_valid), .msg_ready(rdy[2]), .msg_data(msg_data),
      .msg_last(msg_last), .msg_bytes(msg_bytes),
      .done(dn[2]), .result(res_c), .busy(bsy[2]));

   always_comb begin
      rdy_s = rdy[sel];
      dn_s  = dn[sel];
      bsy_s = bsy[sel];
      case (sel)
         0:       res_s = {64'h0, res_a};
         1:       res_s = res_b;
         default: res_s = {64'h0, res_c};
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int cr(input int s); return (s == 2) ? 4 : 2; endfunction
   function automatic int dr(input int s); return (s == 2) ? 8 : 4; endfunction
   function automatic int hr(input int s); return (s == 1) ? 1 : 0; endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Reference model, written from the algorithm definition; state packed as {v3,v2,v1,v0}.
   function automatic logic [255:0] sround(input logic [255:0] s);
      logic [63:0] a, b, c, d;
      a = s[63:0]; b = s[127:64]; c = s[191:128]; d = s[255:192];
      a = a + b; b = {b[50:0], b[63:51]}; b = b ^ a; a = {a[31:0], a[63:32]};
      c = c + d; d = {d[47:0], d[63:48]}; d = d ^ c;
      a = a + d; d = {d[42:0], d[63:43]}; d = d ^ a;
      c = c + b; b = {b[46:0], b[63:47]}; b = b ^ c; c = {c[31:0], c[63:32]};
      return {d, c, b, a};
   endfunction

   function automatic logic [127:0] sip_model(input int c, input int d, input int h,
                                              input logic [127:0] k, input int len);
      logic [255:0] s;
      logic [63:0]  k0 = k[63:0];
      logic [63:0]  k1 = k[127:64];
      logic [63:0]  m;
      logic [63:0]  h0;
      logic [63:0]  h1 = 64'h0;
      int nb = len / 8;
      s = {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
           k1 ^ 64'h646f72616e646f6d ^ ((h != 0) ? 64'hee : 64'h0), k0 ^ 64'h736f6d6570736575};
      for (int b = 0; b <= nb; b++) begin
         m = 64'h0;
         if (b < nb) begin
            for (int j = 0; j < 8; j++) m[8*j +: 8] = msg[8*b + j];
         end else begin
            for (int j = 0; j < len % 8; j++) m[8*j +: 8] = msg[8*b + j];
            m[63:56] = 8'(len);
         end
         s[255:192] = s[255:192] ^ m;
         for (int r = 0; r < c; r++) s = sround(s);
         s[63:0] = s[63:0] ^ m;
      end
      s[191:128] = s[191:128] ^ ((h != 0) ? 64'hee : 64'hff);
      for (int r = 0; r < d; r++) s = sround(s);
      h0 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
      if (h != 0) begin
         s[127:64] = s[127:64] ^ 64'hdd;
         for (int r = 0; r < d; r++) s = sround(s);
         h1 = s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
      end
      return {h1, h0};
   endfunction

   // Output monitor: latency from last-beat handshake, result, single pulse, busy drop.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (msg_valid && rdy_s && msg_last) t_last = cyc;
         if (dn_s) begin
            chk("single_done_pulse", prev_done, 0);
            if (sb.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL unexpected_done: got done=1, required no pending hash");
            end else begin
               sb_t e;
               e = sb.pop_front();
               chk("result", res_s, e.res);
               chk("done_latency", cyc - t_last, e.lat);
               chk("busy_in_done_cycle", bsy_s, 0);
            end
         end
         prev_done = dn_s;
      end
   end

   task automatic start_cmd(input int s, input logic [127:0] k, input bit hold);
      sel  = s;
      cs_v = 3'b001 << s;
      we   = 1'b1;
      key  = k;
      @(posedge clk); #1;
      if (!hold) begin
         cs_v = '0;
         we   = 1'b0;
         key  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic send_beat(input logic [63:0] d, input bit last, input logic [2:0] nb);
      bit ok = 0;
      msg_data  = d;
      msg_last  = last;
      msg_bytes = nb;
      msg_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = rdy_s;
         @(posedge clk); #1;
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL handshake_timeout: got msg_ready=0 for 200 cycles, required 1");
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL done_timeout: got %0d pending hashes, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run_hash(input int s, input logic [127:0] k, input int len,
                           input logic [127:0] exp, input bit known,
                           input bit gaps, input bit hold, input bit tchk);
      sb_t e;
      logic [63:0] d;
      int nb = len / 8;
      e.res = known ? exp : sip_model(cr(s), dr(s), hr(s), k, len);
      e.lat = cr(s) + dr(s) * (1 + hr(s)) + 1;
      start_cmd(s, k, hold);
      if (tchk) begin
         @(negedge clk);
         chk("ready_after_start", rdy_s, 1);
         chk("busy_after_start", bsy_s, 1);
         @(posedge clk); #1;
      end
      for (int b = 0; b <= nb; b++) begin
         if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         d = {$urandom, $urandom};
         for (int j = 0; j < 8; j++)
            if (b < nb || j < len % 8) d[8*j +: 8] = msg[8*b + j];
         if (hold) key = {$urandom, $urandom, $urandom, $urandom};
         if (b == nb) begin
            sb.push_back(e);
            send_beat(d, 1'b1, 3'(len % 8));
         end else begin
            send_beat(d, 1'b0, 3'($urandom_range(0, 7)));
         end
         if (tchk && b == 0 && nb > 0) begin
            for (int r = 0; r < cr(s); r++) begin
               @(negedge clk);
               chk("ready_low_during_comp", rdy_s, 0);
            end
            @(negedge clk);
            chk("ready_reasserts", rdy_s, 1);
            @(posedge clk); #1;
         end
      end
      if (hold) begin cs_v = '0; we = 1'b0; end
      wait_idle();
   endtask

   task automatic fill_inc();
      for (int i = 0; i < 512; i++) msg[i] = 8'(i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required $finish");
      $fatal(1);
   end

   initial begin
      int lens[6];
      logic [127:0] k2;
      rst_n = 1'b0; cs_v = '0; we = 1'b0; key = '0; sel = 0;
      msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;

      vt[0] = '{0, 0,  KEY, 128'h726fdb47dd0e0e31, 1, 1};
      vt[1] = '{0, 15, KEY, 128'ha129ca6149be45e5, 1, 1};
      vt[2] = '{1, 0,  KEY, 128'h930255c71472f66de6a825ba047f81a3, 1, 1};
      vt[3] = '{1, 15, KEY, 128'h0, 0, 0};
      vt[4] = '{2, 8,  KEY, 128'h0, 0, 1};
      vt[5] = '{0, 7,  ~KEY, 128'h0, 0, 0};
      vt[6] = '{2, 1,  KEY, 128'h0, 0, 0};
      vt[7] = '{0, 64, KEY, 128'h0, 0, 0};

      #3;
      chk("reset_done", dn, 0);
      chk("reset_busy", bsy, 0);
      chk("reset_ready", rdy, 0);
      chk("reset_result_a", res_a, 0);
      chk("reset_result_b", res_b, 0);
      chk("reset_result_c", res_c, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         fill_inc();
         run_hash(vt[i].sel, vt[i].k, vt[i].len, vt[i].exp, vt[i].known, 0, 0, vt[i].tchk);
      end

      // result must survive a new start until the next done
      fill_inc();
      run_hash(0, KEY, 0, 128'h726fdb47dd0e0e31, 1, 0, 0, 0);
      start_cmd(0, KEY, 0);
      @(negedge clk);
      chk("result_holds_on_start", res_s, 128'h726fdb47dd0e0e31);
      @(posedge clk); #1;
      sb.push_back('{128'ha129ca6149be45e5, 7});
      send_beat(64'h0706050403020100, 1'b0, 3'd0);
      send_beat(64'hff0e0d0c0b0a0908, 1'b1, 3'd7);
      wait_idle();

      // start held high and key changing mid-hash
      fill_rand();
      k2 = {$urandom, $urandom, $urandom, $urandom};
      run_hash(0, k2, 20, 128'h0, 0, 1, 1, 0);
      run_hash(2, k2, 17, 128'h0, 0, 1, 1, 0);

      // asynchronous reset while compressing
      start_cmd(0, KEY, 0);
      send_beat(64'h0123456789abcdef, 1'b0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_done", dn_s, 0);
      chk("arst_busy", bsy_s, 0);
      chk("arst_ready", rdy_s, 0);
      chk("arst_result", res_s, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill_inc();
      run_hash(0, KEY, 15, 128'ha129ca6149be45e5, 1, 0, 0, 1);

      // 4-8 random messages with length wrap and valid gaps
      lens = '{255, 256, 257, 300, 0, 16};
      for (int i = 0; i < 12; i++) begin
         fill_rand();
         run_hash(2, {$urandom, $urandom, $urandom, $urandom},
                  (i < 6) ? lens[i] : int'($urandom_range(0, 300)), 128'h0, 0, 1, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
